// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the FIFO write-side arbitration logic.
package fifo_ctrl_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BURST_DEF = 4;

    // Source-id width; a lone requester still needs one bit to carry an id.
    function automatic int src_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // ptr is always < N, so one conditional subtract is a full modulo.
    function automatic int wrap(input int a);
        return (a >= N) ? a - N : a;
    endfunction

    logic [N-1:0] rot;
    int           off;

    // Rotate the request vector so position 0 is the current pointer.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++)
            rot[i] = req[wrap(int'(ptr) + i)];
    end

    // Priority-encode the rotated vector; lowest offset wins.
    always_comb begin
        found = 1'b0;
        off   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = i;
            end
        end
    end

    // Un-rotate the winning offset back into a requester index.
    assign idx = W'(wrap(int'(ptr) + off));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter  int NUM_REQ   = NUM_REQ_DEF,
    parameter  int DATA_W    = 128,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    localparam int SRC_W     = src_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wren,
    output logic [DATA_W-1:0]         fifo_wrdata,
    output logic [SRC_W-1:0]          grant_id,
    output logic                      busy
);

    localparam int                CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [SRC_W-1:0]  LAST_IDX  = SRC_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);

    arb_state_t       state, state_nxt;
    logic [SRC_W-1:0] owner, owner_nxt;
    logic [SRC_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt, beat_inc;
    logic             pick_found;
    logic [SRC_W-1:0] pick_idx;
    logic             accept, rel;

    rr_pick #(.N(NUM_REQ), .W(SRC_W)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Word handshake and release detection; a full FIFO blocks both.
    always_comb begin
        busy     = (state == GRANT);
        accept   = busy & req_valid[owner] & ~fifo_full;
        beat_inc = beat_cnt + 1'b1;
        rel      = accept & (req_last[owner] | (beat_inc == BURST_MAX));
    end

    // State and counters; reset aborts any packet in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Next state: pick in IDLE, count beats and hand the pointer on in GRANT.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt    = GRANT;
                    owner_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (accept)
                    beat_cnt_nxt = beat_inc;
                if (rel) begin
                    state_nxt  = IDLE;
                    // Explicit compare so non-power-of-2 NUM_REQ wraps correctly.
                    rr_ptr_nxt = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output muxing; everything is held at zero outside a grant.
    always_comb begin
        req_ready   = '0;
        fifo_wren   = 1'b0;
        fifo_wrdata = '0;
        grant_id    = '0;
        if (busy) begin
            req_ready[owner] = ~fifo_full;
            fifo_wren        = accept;
            fifo_wrdata      = req_data[int'(owner)*DATA_W +: DATA_W];
            grant_id         = owner;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            fifo_full, fifo_wren, busy;
    logic [DW-1:0]   fifo_wrdata;
    logic [1:0]      grant_id;

    // three-requester instance for the wrap check
    logic [2:0]      v3, l3, rdy3;
    logic [3*DW-1:0] d3;
    logic            wr3, busy3;
    logic [DW-1:0]   wd3;
    logic [1:0]      gid3;

    logic [11:0] seq [N];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata), .grant_id(grant_id),
        .busy(busy));

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_W(DW), .MAX_BURST(MB)) dut3 (
        .clk(clk), .reset(reset), .req_valid(v3), .req_data(d3),
        .req_last(l3), .req_ready(rdy3), .fifo_full(1'b0),
        .fifo_wren(wr3), .fifo_wrdata(wd3), .grant_id(gid3), .busy(busy3));

    // producer i offers {i+1, seq[i]}; seq advances only on acceptance
    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++)
            req_data[i*DW +: DW] = {4'(i + 1), seq[i]};
    end

    always_comb begin
        d3 = '0;
        for (int i = 0; i < 3; i++)
            d3[i*DW +: DW] = {4'(i + 1), 12'h5A0};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input bit b, input int g);
        return b ? {4'(g + 1), seq[g]} : '0;
    endfunction

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0;
        v3 = '0; l3 = '0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] v, l;
        logic         f;
        logic [N-1:0] rdy;
        logic         wr;
        logic [1:0]   gid;
        logic         bsy;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, l, input logic f,
                                input logic [3:0] rdy, input logic wr,
                                input logic [1:0] gid, input logic bsy);
        vec_t t;
        t.v = v; t.l = l; t.f = f; t.rdy = rdy; t.wr = wr; t.gid = gid; t.bsy = bsy;
        return t;
    endfunction

    // reference model state
    bit        m_busy;
    int        m_owner, m_cnt, m_ptr;
    int        gseq[$];

    initial begin
        vec_t tbl[$];
        for (int i = 0; i < N; i++) seq[i] = '0;

        // ---------------- reset state
        do_reset();
        #1;
        chk("rst_busy",  busy, 0);
        chk("rst_gid",   grant_id, 0);
        chk("rst_wren",  fifo_wren, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_data",  fifo_wrdata, 0);
        @(negedge clk);

        // ---------------- table: single producer, pointer follow-on, full, owner gap
        tbl.push_back(mk(4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 4'b0000, 0, 4'b0100, 1, 2, 1));
        tbl.push_back(mk(4'b0100, 4'b0000, 0, 4'b0100, 1, 2, 1));
        tbl.push_back(mk(4'b0100, 4'b0100, 0, 4'b0100, 1, 2, 1));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(4'b0011, 4'b0000, 0, 4'b0000, 0, 0, 0)); // ptr=3 -> wraps to 0
        tbl.push_back(mk(4'b0011, 4'b0001, 0, 4'b0001, 1, 0, 1));
        tbl.push_back(mk(4'b0010, 4'b0000, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 1));
        for (int k = 0; k < 5; k++)                                 // full together with last
            tbl.push_back(mk(4'b0010, 4'b0010, 1, 4'b0000, 0, 1, 1));
        tbl.push_back(mk(4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 1));
        tbl.push_back(mk(4'b1000, 4'b0000, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(4'b1000, 4'b0000, 0, 4'b1000, 1, 3, 1));
        tbl.push_back(mk(4'b0111, 4'b0000, 0, 4'b1000, 0, 3, 1)); // owner gap
        tbl.push_back(mk(4'b0111, 4'b0000, 0, 4'b1000, 0, 3, 1));
        tbl.push_back(mk(4'b1000, 4'b1000, 0, 4'b1000, 1, 3, 1));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            req_valid = tbl[k].v; req_last = tbl[k].l; fifo_full = tbl[k].f;
            #1;
            chk($sformatf("tbl%0d_ready", k), req_ready, tbl[k].rdy);
            chk($sformatf("tbl%0d_wren", k),  fifo_wren, tbl[k].wr);
            chk($sformatf("tbl%0d_gid", k),   grant_id,  tbl[k].gid);
            chk($sformatf("tbl%0d_busy", k),  busy,      tbl[k].bsy);
            chk($sformatf("tbl%0d_data", k),  fifo_wrdata, exp_data(tbl[k].bsy, int'(tbl[k].gid)));
            @(negedge clk);
        end

        // ---------------- all four requesting, no last: bursts of MB, one bubble
        do_reset();
        req_valid = '1;
        foreach (gseq[i]) ;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk($sformatf("rr%0d_bubble", g), busy, 0);
            @(negedge clk);
            for (int b = 0; b < MB; b++) begin
                #1;
                chk($sformatf("rr%0d_b%0d_wren", g, b), fifo_wren, 1);
                chk($sformatf("rr%0d_b%0d_gid", g, b),  grant_id, g % N);
                @(negedge clk);
            end
        end

        // ---------------- reset mid-grant: pointer must return to 0
        do_reset();
        req_valid = 4'b0010; req_last = 4'b0010;
        @(negedge clk); @(negedge clk);            // grant 1, single word -> ptr=2
        req_valid = 4'b0100; req_last = '0;
        @(negedge clk);                            // idle picks 2
        #1; chk("mid_w1_gid", grant_id, 2);
        @(negedge clk);
        reset = 1'b1;
        #1; chk("mid_w2_wren", fifo_wren, 1);
        @(negedge clk);
        reset = 1'b0; req_valid = '0;
        #1;
        chk("mid_busy",  busy, 0);
        chk("mid_gid",   grant_id, 0);
        chk("mid_wren",  fifo_wren, 0);
        chk("mid_ready", req_ready, 0);
        chk("mid_data",  fifo_wrdata, 0);
        req_valid = 4'b0110;
        @(negedge clk);
        #1; chk("mid_after_gid", grant_id, 1);
        @(negedge clk);

        // ---------------- randomized run against a behavioural model
        do_reset();
        m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] er;
            bit           ew;
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) req_last[i] = ($urandom_range(0, 3) == 0);
            fifo_full = ($urandom_range(0, 3) == 0);
            #1;
            er = '0; ew = 0;
            if (m_busy) begin
                if (!fifo_full) er[m_owner] = 1'b1;
                ew = req_valid[m_owner] && !fifo_full;
            end
            chk("rnd_ready", req_ready, er);
            chk("rnd_wren",  fifo_wren, ew);
            chk("rnd_busy",  busy, m_busy);
            chk("rnd_gid",   grant_id, m_busy ? m_owner : 0);
            chk("rnd_data",  fifo_wrdata, exp_data(m_busy, m_owner));
            // advance model using this cycle's inputs
            if (!m_busy) begin
                for (int k = N - 1; k >= 0; k--)
                    if (req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                if (req_valid != 0) begin m_busy = 1; m_cnt = 0; end
            end else if (ew) begin
                seq[m_owner] = seq[m_owner] + 1'b1;
                m_cnt++;
                if (req_last[m_owner] || m_cnt == MB) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end
            @(negedge clk);
        end

        // ---------------- wrap with three requesters, 0 and 2 active
        do_reset();
        req_valid = '0;
        v3 = 3'b101; l3 = 3'b101;
        gseq.delete();
        for (int c = 0; c < 8; c++) begin
            #1;
            if (busy3) gseq.push_back(int'(gid3));
            @(negedge clk);
        end
        chk("wrap_count", gseq.size(), 4);
        for (int k = 0; k < 4 && k < gseq.size(); k++)
            chk($sformatf("wrap_g%0d", k), gseq[k], (k % 2 == 0) ? 0 : 2);
        v3 = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the synchronous FIFO between `NUM_REQ` producers. Each producer offers a valid/ready stream of data words, optionally grouped into packets by a `last` flag. The arbiter grants one producer at a time, forwards its words to the FIFO write port, and back-pressures on FIFO full. It sits directly in front of the FIFO and drives its `wren`/`wrdata` inputs.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `DATA_W`, 128: data word width; matches the FIFO data width.
- `MAX_BURST`, 4: maximum words per grant before forced release, 1..255.
- `SRC_W`, `$clog2(NUM_REQ)`: width of the source id (localparam).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, `NUM_REQ`: producer i has a word.
- `req_data`, in, `NUM_REQ*DATA_W`: producer i word in slice `[i*DATA_W +: DATA_W]`.
- `req_last`, in, `NUM_REQ`: word is the last of producer i's packet.
- `req_ready`, out, `NUM_REQ`: word accepted when valid & ready.
- `fifo_full`, in, 1: FIFO full flag.
- `fifo_wren`, out, 1: FIFO write enable.
- `fifo_wrdata`, out, `DATA_W`: FIFO write data.
- `grant_id`, out, `SRC_W`: current owner; 0 when idle.
- `busy`, out, 1: a grant is active.

## Operation
- FSM states are IDLE and GRANT.
- **IDLE**
  - No `req_ready` is asserted and `fifo_wren` = 0.
  - If any `req_valid` is high, the arbiter picks the first requester at or after `rr_ptr` (modulo `NUM_REQ`).
  - It loads `owner`, clears `beat_cnt`, and moves to GRANT.
- **GRANT**
  - `req_ready[owner]` = !`fifo_full`. All other `req_ready` = 0.
  - `fifo_wren` = `req_valid[owner]` & !`fifo_full`.
  - `fifo_wrdata` = the owner's data slice, combinational pass-through.
  - Each accepted word increments `beat_cnt`.
  - Release happens on an accepted word with `req_last[owner]` = 1, or when `beat_cnt` reaches `MAX_BURST`.
  - On release: `rr_ptr` = (`owner`+1) mod `NUM_REQ`, then return to IDLE.
  - If the owner deasserts `req_valid` mid-packet, the grant is held and nothing is written.
- `fifo_wren` is never asserted while `fifo_full` = 1, so no write is ever dropped.
- `beat_cnt` width is `$clog2(MAX_BURST+1)`. It saturates by construction because release happens at `MAX_BURST`.
- `rr_ptr` wraps from `NUM_REQ-1` to 0. For non-power-of-2 `NUM_REQ`, the wrap is an explicit compare, not a bit overflow.
- When `fifo_full` and `req_last` occur together: the word is not accepted, so there is no release, and the grant holds.

## Timing
- Arbitration latency is 1 cycle: a request seen in IDLE at cycle N is first accepted at cycle N+1 at the earliest.
- After release there is a 1-cycle IDLE bubble before the next grant. Peak throughput is `MAX_BURST`/(`MAX_BURST`+1).
- `fifo_wren`, `fifo_wrdata` and `req_ready` are combinational from registered state plus `fifo_full` and `req_valid`. There are no combinational paths from `req_data` to any control output.
- Reset values:
  - State = IDLE.
  - `owner` = 0, `rr_ptr` = 0, `beat_cnt` = 0.
  - Outputs: `busy` = 0, `grant_id` = 0, `fifo_wren` = 0, `req_ready` = 0, `fifo_wrdata` = 0.
- Reset asserted mid-GRANT aborts the packet in the same clock edge. Words already written stay in the FIFO. Clearing the FIFO is the FIFO's own reset.

## Structure
- Package `fifo_ctrl_pkg` holds:
  - the state enum `arb_state_t` {IDLE, GRANT};
  - the `NUM_REQ` and `MAX_BURST` defaults;
  - the `SRC_W` function.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector and `ptr`.
  - Outputs: `found` and `idx`.
  - Implemented as a rotate, priority-encode, un-rotate.
- The top module holds the FSM, counters and muxing.

## Test plan
- **Single producer:** only `req_valid[2]`, 3 words, last on the 3rd. Expect IDLE for 1 cycle, then 3 consecutive `fifo_wren` with `grant_id` = 2, then `busy` falls and `rr_ptr` = 3.
- **All four requesting continuously:** `MAX_BURST` = 4, `last` never set. Expect grants in order 0,1,2,3,0; exactly 4 writes per grant; one bubble between grants.
- **Full back-pressure:** `fifo_full` = 1 for 5 cycles mid-packet. Expect `fifo_wren` = 0 and `req_ready` = 0 throughout, grant held, writes resume on the first cycle `fifo_full` = 0, and no word is lost or duplicated.
- **Owner gap:** owner drops `req_valid` for 2 cycles mid-packet while others request. Expect no grant change and no writes during the gap.
- **Reset mid-grant:** assert `reset` on the 2nd word. Expect the next cycle state = IDLE, all outputs at reset values, and `rr_ptr` = 0.
- **Wrap check:** `NUM_REQ` = 3, requesters 0 and 2 active, after a grant to 2. Expect the next grant to be 0.
